// File: rtl/cmp_stream_stats_pkg.sv
// Shared definitions for the compare-stream statistics block.
package cmp_stream_stats_pkg;

    localparam int DATA_W_DEF = 4;
    localparam int CNT_W_DEF  = 4;

    // Running minimum starts at the largest representable sample.
    localparam logic [DATA_W_DEF-1:0] MIN_INIT = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/cmp_stream_stats_mag_compare.sv
// Combinational unsigned magnitude compare: lt = a < b, eq = a == b.
module mag_compare #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         lt,
    output logic         eq
);

    // Both operands are treated as plain unsigned values of the same width.
    always_comb begin
        lt = (a < b);
        eq = (a == b);
    end

endmodule

// File: rtl/cmp_stream_stats.sv
// Burst statistics: running min, running max and count of samples below a
// threshold, collected over a length-prefixed valid/ready sample burst.
module cmp_stream_stats
    import cmp_stream_stats_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  len,
    input  logic [DATA_W-1:0] thresh,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_min,
    output logic [DATA_W-1:0] out_max,
    output logic [CNT_W-1:0]  out_below,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);

    localparam logic [DATA_W-1:0] MIN_PRESET = {DATA_W{1'b1}};

    state_e            state_q, state_d;
    logic [DATA_W-1:0] thresh_q, thresh_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [DATA_W-1:0] min_q, min_d;
    logic [DATA_W-1:0] max_q, max_d;
    logic [CNT_W-1:0]  below_q, below_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;

    logic lt_min, eq_min, lt_max, eq_max, lt_thr, eq_thr;
    logic accept;

    // sample < min
    mag_compare #(.W(DATA_W)) u_cmp_min (
        .a  (in_data),
        .b  (min_q),
        .lt (lt_min),
        .eq (eq_min)
    );

    // max < sample
    mag_compare #(.W(DATA_W)) u_cmp_max (
        .a  (max_q),
        .b  (in_data),
        .lt (lt_max),
        .eq (eq_max)
    );

    // sample < latched threshold
    mag_compare #(.W(DATA_W)) u_cmp_thr (
        .a  (in_data),
        .b  (thresh_q),
        .lt (lt_thr),
        .eq (eq_thr)
    );

    // Equality carries no information here: strict less-than drives every update.
    logic unused_eq;
    assign unused_eq = eq_min ^ eq_max ^ eq_thr;

    assign accept = in_valid && in_ready_q;

    // Next-state and next-output computation for the IDLE/ACCUM/DONE sequence.
    always_comb begin
        state_d     = state_q;
        thresh_d    = thresh_q;
        rem_d       = rem_q;
        min_d       = min_q;
        max_d       = max_q;
        below_d     = below_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    thresh_d = thresh;
                    rem_d    = len;
                    min_d    = MIN_PRESET;
                    max_d    = '0;
                    below_d  = '0;
                    busy_d   = 1'b1;
                    if (len != '0) begin
                        state_d    = ST_ACCUM;
                        in_ready_d = 1'b1;
                    end else begin
                        state_d     = ST_DONE;
                        out_valid_d = 1'b1;
                    end
                end
            end
            ST_ACCUM: begin
                if (accept) begin
                    if (lt_min) min_d = in_data;
                    if (lt_max) max_d = in_data;
                    if (lt_thr) below_d = below_q + 1'b1;
                    rem_d = rem_q - 1'b1;
                    if (rem_q == CNT_W'(1)) begin
                        state_d     = ST_DONE;
                        in_ready_d  = 1'b0;
                        out_valid_d = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                // A start here is ignored; only the result handshake matters.
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                in_ready_d  = 1'b0;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    // State and all outputs registered; async reset aborts any burst in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            thresh_q    <= '0;
            rem_q       <= '0;
            min_q       <= MIN_PRESET;
            max_q       <= '0;
            below_q     <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            thresh_q    <= thresh_d;
            rem_q       <= rem_d;
            min_q       <= min_d;
            max_q       <= max_d;
            below_q     <= below_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_min   = min_q;
    assign out_max   = max_q;
    assign out_below = below_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_cmp_stream_stats.sv
// Scoreboard bench for cmp_stream_stats: expected results queued at start,
// checked by an independent monitor whenever results are presented.
module tb_cmp_stream_stats;
    import cmp_stream_stats_pkg::*;

    typedef struct packed {
        logic [3:0] mn;
        logic [3:0] mx;
        logic [3:0] bl;
    } res_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] len = '0;
    logic [3:0] thresh = '0;
    logic [3:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic       in_ready, out_valid, busy;
    logic [3:0] out_min, out_max, out_below;

    res_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    cmp_stream_stats #(.DATA_W(4), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .thresh    (thresh),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_min   (out_min),
        .out_max   (out_max),
        .out_below (out_below),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic burst(input logic [3:0] l, input logic [3:0] t, input bit push, input res_t e);
        if (push) exp_q.push_back(e);
        len = l;
        thresh = t;
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic send(input logic [3:0] d, input int gap);
        in_valid = 1'b0;
        repeat (gap) tick;
        in_valid = 1'b1;
        in_data = d;
        for (int i = 0; i < 20 && !in_ready; i++) tick;
        if (!in_ready) chk("in_ready_timeout", in_ready, 1);
        tick;
        in_valid = 1'b0;
    endtask

    // Monitor: results presented are compared against the queue head and
    // popped on the handshake; held results are re-checked every cycle.
    initial begin
        res_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", out_valid, 0);
                end else begin
                    e = exp_q[0];
                    chk("out_min", out_min, e.mn);
                    chk("out_max", out_max, e.mx);
                    chk("out_below", out_below, e.bl);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        // Reset state
        #12;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_min", out_min, MIN_INIT);
        chk("rst_out_max", out_max, 0);
        chk("rst_out_below", out_below, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick;

        // Basic burst
        burst(4'd4, 4'd5, 1'b1, '{mn: 4'd2, mx: 4'd9, bl: 4'd1});
        send(4'd7, 0); send(4'd2, 0); send(4'd9, 0); send(4'd5, 0);
        chk("basic_latency_valid", out_valid, 1);
        chk("basic_in_ready_drop", in_ready, 0);
        tick;
        chk("basic_back_idle", out_valid, 0);
        chk("basic_busy_clear", busy, 0);

        // Input stalls and output backpressure
        out_ready = 1'b0;
        burst(4'd3, 4'd8, 1'b1, '{mn: 4'd3, mx: 4'd15, bl: 4'd2});
        send(4'd3, 2); send(4'd3, 2); send(4'd15, 2);
        chk("stall_latency_valid", out_valid, 1);
        repeat (5) tick;
        chk("stall_held_valid", out_valid, 1);
        chk("stall_held_busy", busy, 1);
        out_ready = 1'b1;
        tick;
        chk("stall_back_idle", out_valid, 0);
        chk("stall_busy_clear", busy, 0);

        // Boundary values
        burst(4'd2, 4'd0, 1'b1, '{mn: 4'd0, mx: 4'd15, bl: 4'd0});
        send(4'd0, 0); send(4'd15, 0);
        chk("bound1_valid", out_valid, 1);
        tick;
        burst(4'd1, 4'd15, 1'b1, '{mn: 4'd15, mx: 4'd15, bl: 4'd0});
        send(4'd15, 0);
        chk("bound2_valid", out_valid, 1);
        tick;

        // Zero length
        in_data = 4'd3;
        burst(4'd0, 4'd9, 1'b1, '{mn: 4'd15, mx: 4'd0, bl: 4'd0});
        chk("zero_valid", out_valid, 1);
        chk("zero_in_ready", in_ready, 0);
        tick;
        chk("zero_back_idle", out_valid, 0);

        // Illegal starts in ACCUM and DONE
        burst(4'd4, 4'd5, 1'b1, '{mn: 4'd1, mx: 4'd4, bl: 4'd4});
        send(4'd1, 0); send(4'd2, 0);
        len = 4'd0;
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("accum_start_ignored", in_ready, 1);
        send(4'd3, 0); send(4'd4, 0);
        chk("ill_valid", out_valid, 1);
        out_ready = 1'b0;
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("done_start_valid", out_valid, 1);
        chk("done_start_min", out_min, 1);
        tick;
        start = 1'b1;
        out_ready = 1'b1;
        tick;
        start = 1'b0;
        chk("handoff_start_valid", out_valid, 0);
        chk("handoff_start_busy", busy, 0);
        chk("handoff_start_in_ready", in_ready, 0);

        // Reset mid-burst
        burst(4'd4, 4'd7, 1'b0, '{mn: 4'd0, mx: 4'd0, bl: 4'd0});
        send(4'd2, 0); send(4'd5, 0);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 0);
        chk("abort_out_min", out_min, 15);
        chk("abort_out_below", out_below, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick;
        burst(4'd1, 4'd7, 1'b1, '{mn: 4'd6, mx: 4'd6, bl: 4'd1});
        send(4'd6, 0);
        chk("fresh_valid", out_valid, 1);
        tick;

        // Maximum length
        burst(4'd15, 4'd10, 1'b1, '{mn: 4'd0, mx: 4'd14, bl: 4'd10});
        for (int i = 0; i < 15; i++) send(4'(i), 0);
        chk("maxlen_valid", out_valid, 1);
        chk("maxlen_below", out_below, 10);
        tick;
        chk("maxlen_back_idle", out_valid, 0);

        repeat (2) tick;
        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
